// File: rtl/sync_evt_arb_pkg.sv
// sync_evt_arb shared types: FSM states, warm-up counter width and
// the round-robin search helper used by the arbiter.
package sync_evt_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    localparam int WU_W  = 8;
    localparam int MAX_N = 64;

    // First set bit of req searching from (ptr+1) mod n upward with wrap.
    // Walking offsets downward lets the smallest offset win last.
    function automatic int rr_next(
        input logic [MAX_N-1:0] req,
        input int               n,
        input int               ptr
    );
        logic [5:0] idx;
        rr_next = ptr;
        for (int k = MAX_N; k >= 1; k--) begin
            idx = 6'((ptr + k) % n);
            if (k <= n && req[idx]) begin
                rr_next = int'(idx);
            end
        end
    endfunction

endpackage

// File: rtl/sync_evt_arb_sync_bit.sv
// sync_bit: SYNC_STAGES-deep flop chain bringing one asynchronous
// line into the clk_i domain; synchronous reset clears the chain.
module sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_chain;

    // Shift the raw line through the chain; oldest stage is the output.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/sync_evt_arb.sv
// sync_evt_arb: synchronizes N event lines, latches edges as pending
// requests, serializes them round-robin onto one valid/ready port.
// Define SYNC_EVT_ARB_BOTHEDGE_EN to make falling edges events too.
module sync_evt_arb
    import sync_evt_arb_pkg::*;
#(
    parameter  int N           = 4,
    parameter  int SYNC_STAGES = 2,
    localparam int IDW         = $clog2(N)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [N-1:0]   evt_i,
    output logic           evt_valid_o,
    output logic [IDW-1:0] evt_id_o,
    input  logic           evt_ready_i,
    output logic [N-1:0]   pend_o,
    output logic           ovf_o
);

    logic [N-1:0]    w_sync;
    logic [N-1:0]    w_edge;
    logic [N-1:0]    w_clr;
    logic [N-1:0]    r_hist;
    logic [N-1:0]    r_pend;
    logic [WU_W-1:0] r_wu;
    logic            w_wu_done;
    logic            w_take;
    logic [IDW-1:0]  w_pick;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_id;
    logic            r_valid;
    logic            r_ovf;
    state_t          r_state;

    for (genvar g = 0; g < N; g++) begin : g_sync
        sync_bit #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .i_clk(clk_i),
            .i_rst(rst_i),
            .i_d  (evt_i[g]),
            .o_q  (w_sync[g])
        );
    end

    assign w_wu_done = (r_wu == WU_W'(SYNC_STAGES + 1));

    // Edges are masked until the chains have flushed after reset.
    always_comb begin
        w_edge = '0;
        if (w_wu_done) begin
`ifdef SYNC_EVT_ARB_BOTHEDGE_EN
            w_edge = w_sync ^ r_hist;
`else
            w_edge = w_sync & ~r_hist;
`endif
        end
    end

    // Pick the next request; a pick happens from IDLE or on handshake.
    always_comb begin
        w_pick = IDW'(rr_next(MAX_N'(r_pend), N, int'(r_ptr)));
        w_take = 1'b0;
        case (r_state)
            IDLE:    w_take = |r_pend;
            OFFER:   w_take = evt_ready_i & (|r_pend);
            default: w_take = 1'b0;
        endcase
        w_clr = w_take ? (N'(1) << w_pick) : '0;
    end

    // Edge history follows the synced value; warm-up counter saturates.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hist <= '0;
            r_wu   <= '0;
        end else begin
            r_hist <= w_sync;
            if (!w_wu_done) begin
                r_wu <= r_wu + 1'b1;
            end
        end
    end

    // New edges win over a same-cycle clear; re-edge on pending flags ovf.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pend <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_edge;
            if (|(w_edge & r_pend & ~w_clr)) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Offer FSM: outputs held stable until the consumer takes the event.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_id    <= '0;
            r_ptr   <= IDW'(N - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_id    <= w_pick;
                        r_ptr   <= w_pick;
                        r_valid <= 1'b1;
                        r_state <= OFFER;
                    end
                end
                OFFER: begin
                    if (evt_ready_i) begin
                        if (w_take) begin
                            r_id  <= w_pick;
                            r_ptr <= w_pick;
                        end else begin
                            r_valid <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign evt_valid_o = r_valid;
    assign evt_id_o    = r_id;
    assign pend_o      = r_pend;
    assign ovf_o       = r_ovf;

endmodule
